// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: AHB-Lite signal bundle between a master/decoder and one slave.
interface ahb_slave_mem_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite word memory slave with WAIT_CYCLES wait states per transfer.
// Define AHB_SLAVE_ERR_RESP_EN to answer out-of-range addresses with a two-cycle ERROR.
module ahb_slave_mem #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 1
) (
    input logic CLK,
    input logic RST,
    ahb_slave_mem_if.slave bus
);
    localparam int WORDS = 1 << (ADDR_W - 2);
    localparam logic [1:0] WAIT_INIT = 2'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
    typedef enum logic [2:0] {IDLE, WAIT, DONE, ERR1, ERR2} state_t;
    state_t state;
    logic [31:0] mem [WORDS];
    logic [31:0] rdata, rd_data;
    logic [1:0] cnt;
    logic [ADDR_W-3:0] idx, rd_idx, addr_idx;
    logic wr, ready, resp, oor, accept, wr_done, rd_load, unused;
    assign addr_idx = bus.HADDR[ADDR_W-1:2];
`ifdef AHB_SLAVE_ERR_RESP_EN
    assign oor    = |bus.HADDR[31:ADDR_W];
    assign unused = ^{bus.HADDR[1:0], bus.HTRANS[0]};
`else
    assign oor    = 1'b0;
    assign unused = ^{bus.HADDR[31:ADDR_W], bus.HADDR[1:0], bus.HTRANS[0]};
`endif
    assign accept  = (state == IDLE || state == DONE || state == ERR2) &&
                     bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign wr_done = state == DONE && wr;
    // With no wait states a read loads straight from the address phase.
    assign rd_load = (accept && !oor && !bus.HWRITE && WAIT_CYCLES == 0) ||
                     (state == WAIT && cnt == 2'd0 && !wr);
    assign rd_idx  = state == WAIT ? idx : addr_idx;
    assign rd_data = wr_done && idx == rd_idx ? bus.HWDATA : mem[rd_idx];
    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = ready;
    assign bus.HRESP     = resp;
    always_ff @(posedge CLK)
        if (wr_done && !RST) mem[idx] <= bus.HWDATA;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= 2'd0;
            ready <= 1'b1;
            resp  <= 1'b0;
            rdata <= 32'h0;
        end else begin
            if (rd_load) rdata <= rd_data;
            if (accept) begin
                idx   <= addr_idx;
                wr    <= bus.HWRITE;
                state <= oor ? ERR1 : (WAIT_CYCLES > 0 ? WAIT : DONE);
                cnt   <= WAIT_INIT;
                ready <= !oor && WAIT_CYCLES == 0;
                resp  <= oor;
            end else if (state == WAIT) begin
                state <= cnt == 2'd0 ? DONE : WAIT;
                cnt   <= cnt == 2'd0 ? 2'd0 : cnt - 2'd1;
                ready <= cnt == 2'd0;
                resp  <= 1'b0;
            end else if (state == ERR1) begin
                state <= ERR2;
                ready <= 1'b1;
                resp  <= 1'b1;
            end else begin
                state <= IDLE;
                ready <= 1'b1;
                resp  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: directed checks of ahb_slave_mem with 0, 1 and 3 wait states.
module tb_ahb_slave_mem;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [2:0] hsel = 3'b0;
    logic [31:0] haddr = 32'h0, hwdata = 32'h0;
    logic [1:0] htrans = 2'b00;
    logic hwrite = 1'b0, hready = 1'b1;
    logic rdy [3];
    logic rsp [3];
    logic [31:0] rdat [3];
    int checks = 0, errors = 0;
    int waits;
    logic resp_first, resp_end;
    logic [31:0] rd;

    always #5 CLK = ~CLK;

    ahb_slave_mem_if i0 ();
    ahb_slave_mem_if i1 ();
    ahb_slave_mem_if i3 ();
    ahb_slave_mem #(.WAIT_CYCLES(0)) d0 (.CLK(CLK), .RST(RST), .bus(i0));
    ahb_slave_mem #(.WAIT_CYCLES(1)) d1 (.CLK(CLK), .RST(RST), .bus(i1));
    ahb_slave_mem #(.WAIT_CYCLES(3)) d3 (.CLK(CLK), .RST(RST), .bus(i3));

    assign i0.HSEL = hsel[0];
    assign i1.HSEL = hsel[1];
    assign i3.HSEL = hsel[2];
    assign {i0.HADDR, i1.HADDR, i3.HADDR} = {3{haddr}};
    assign {i0.HTRANS, i1.HTRANS, i3.HTRANS} = {3{htrans}};
    assign {i0.HWRITE, i1.HWRITE, i3.HWRITE} = {3{hwrite}};
    assign {i0.HWDATA, i1.HWDATA, i3.HWDATA} = {3{hwdata}};
    assign {i0.HREADY, i1.HREADY, i3.HREADY} = {3{hready}};
    assign rdy[0] = i0.HREADYOUT;
    assign rdy[1] = i1.HREADYOUT;
    assign rdy[2] = i3.HREADYOUT;
    assign rsp[0] = i0.HRESP;
    assign rsp[1] = i1.HRESP;
    assign rsp[2] = i3.HRESP;
    assign rdat[0] = i0.HRDATA;
    assign rdat[1] = i1.HRDATA;
    assign rdat[2] = i3.HRDATA;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_bus();
        hsel = 3'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hready = 1'b1;
    endtask

    // One complete single transfer to slave s: address phase, then data phase until ready.
    task automatic xfer(input int s, input logic [31:0] a, input logic w, input logic [31:0] d);
        hsel = 3'(1 << s);
        haddr = a;
        htrans = 2'b10;
        hwrite = w;
        hready = 1'b1;
        tick();
        idle_bus();
        hwdata = d;
        waits = 0;
        resp_first = 1'b0;
        while (!rdy[s] && waits < 8) begin
            if (waits == 0) resp_first = rsp[s];
            waits++;
            tick();
        end
        if (waits >= 8) check("xfer_timeout", 32'(waits), 32'd0);
        resp_end = rsp[s];
        rd = rdat[s];
        tick();
    endtask

    initial begin
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst_ready%0d", s), 32'(rdy[s]), 32'd1);
            check($sformatf("rst_resp%0d", s), 32'(rsp[s]), 32'd0);
            check($sformatf("rst_rdata%0d", s), rdat[s], 32'h0);
        end
        RST = 1'b0;
        tick();

        // One wait state: write then read back.
        xfer(1, 32'h08, 1'b1, 32'hDEADBEEF);
        check("w1_wr_waits", 32'(waits), 32'd1);
        check("w1_wr_resp", 32'(resp_end), 32'd0);
        check("w1_wr_rdata_hold", rd, 32'h0);
        xfer(1, 32'h08, 1'b0, 32'h0);
        check("w1_rd_waits", 32'(waits), 32'd1);
        check("w1_rd_data", rd, 32'hDEADBEEF);
        xfer(1, 32'h3C, 1'b1, 32'h3C3C0001);
        xfer(1, 32'h0C, 1'b1, 32'hCAFE0001);
        check("w1_rdata_hold", rdat[1], 32'hDEADBEEF);
        xfer(1, 32'h3C, 1'b0, 32'h0);
        check("w1_rd_3c", rd, 32'h3C3C0001);

        // Non-transfers: IDLE and BUSY while selected, NONSEQ while deselected, HREADY low.
        hsel = 3'b010; haddr = 32'h0C; hwrite = 1'b1; htrans = 2'b00;
        tick();
        check("idle_ready", 32'(rdy[1]), 32'd1);
        check("idle_resp", 32'(rsp[1]), 32'd0);
        htrans = 2'b01;
        tick();
        check("busy_ready", 32'(rdy[1]), 32'd1);
        hsel = 3'b000; htrans = 2'b10;
        tick();
        hwdata = 32'h0BAD0001;
        check("unsel_ready", 32'(rdy[1]), 32'd1);
        hsel = 3'b010; hready = 1'b0;
        tick();
        hwdata = 32'h0BAD0002;
        check("hready_low_ready", 32'(rdy[1]), 32'd1);
        check("hready_low_resp", 32'(rsp[1]), 32'd0);
        idle_bus();
        tick();
        tick();
        xfer(1, 32'h0C, 1'b0, 32'h0);
        check("nontransfer_mem", rd, 32'hCAFE0001);

        // Zero wait states: back-to-back write then read of the same word forwards write data.
        xfer(0, 32'h04, 1'b1, 32'h55555555);
        check("w0_wr_waits", 32'(waits), 32'd0);
        xfer(0, 32'h0C, 1'b1, 32'h0C0C0C0C);
        hsel = 3'b001; haddr = 32'h04; hwrite = 1'b1; htrans = 2'b10;
        tick();
        check("b2b_ready_wr", 32'(rdy[0]), 32'd1);
        hwdata = 32'h12345678; hwrite = 1'b0;
        tick();
        idle_bus();
        check("b2b_ready_rd", 32'(rdy[0]), 32'd1);
        check("b2b_fwd", rdat[0], 32'h12345678);
        tick();
        xfer(0, 32'h04, 1'b0, 32'h0);
        check("b2b_mem", rd, 32'h12345678);
        hsel = 3'b001; haddr = 32'h08; hwrite = 1'b1; htrans = 2'b10;
        tick();
        hwdata = 32'h88888888; haddr = 32'h0C; hwrite = 1'b0;
        tick();
        idle_bus();
        check("b2b_nofwd", rdat[0], 32'h0C0C0C0C);
        tick();

        // Upper address bits: ERROR response or aliasing depending on build.
        xfer(1, 32'h00, 1'b1, 32'h0000AAAA);
        xfer(1, 32'h04, 1'b1, 32'h0000BBBB);
        xfer(1, 32'h04, 1'b0, 32'h0);
        xfer(1, 32'h100, 1'b0, 32'h0);
`ifdef AHB_SLAVE_ERR_RESP_EN
        check("oor_waits", 32'(waits), 32'd1);
        check("oor_resp1", 32'(resp_first), 32'd1);
        check("oor_resp2", 32'(resp_end), 32'd1);
        check("oor_rdata", rd, 32'h0000BBBB);
        xfer(1, 32'h104, 1'b1, 32'h00000099);
        xfer(1, 32'h04, 1'b0, 32'h0);
        check("oor_nowrite", rd, 32'h0000BBBB);
`else
        check("alias_waits", 32'(waits), 32'd1);
        check("alias_resp1", 32'(resp_first), 32'd0);
        check("alias_resp2", 32'(resp_end), 32'd0);
        check("alias_rdata", rd, 32'h0000AAAA);
        xfer(1, 32'h104, 1'b1, 32'h00000099);
        xfer(1, 32'h04, 1'b0, 32'h0);
        check("alias_write", rd, 32'h00000099);
`endif

        // Three wait states, reset in the second wait cycle aborts the write.
        xfer(2, 32'h10, 1'b1, 32'h11110000);
        check("w3_wr_waits", 32'(waits), 32'd3);
        xfer(2, 32'h10, 1'b0, 32'h0);
        check("w3_rd_waits", 32'(waits), 32'd3);
        check("w3_rd_data", rd, 32'h11110000);
        hsel = 3'b100; haddr = 32'h10; hwrite = 1'b1; htrans = 2'b10;
        tick();
        idle_bus();
        hwdata = 32'hA5A5A5A5;
        check("abort_wait1", 32'(rdy[2]), 32'd0);
        tick();
        check("abort_wait2", 32'(rdy[2]), 32'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort_ready", 32'(rdy[2]), 32'd1);
        check("abort_resp", 32'(rsp[2]), 32'd0);
        check("abort_rdata", rdat[2], 32'h0);
        tick();
        xfer(2, 32'h10, 1'b0, 32'h0);
        check("abort_mem", rd, 32'h11110000);
        check("abort_rd_waits", 32'(waits), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
